// File: rtl/demux_1_4_collector_pkg.sv
// Shared types and constants for the 1:4 lane collector: FSM encoding,
// lane count and a lane-select decoder.
package demux_1_4_collector_pkg;

  localparam int LANES     = 4;
  localparam int SEL_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILLING  = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  function automatic logic [LANES-1:0] lane_onehot(input logic [SEL_WIDTH-1:0] sel);
    logic [LANES-1:0] hot;
    hot      = '0;
    hot[sel] = 1'b1;
    return hot;
  endfunction

endpackage

// File: rtl/demux_lane.sv
// One lane of the collector: a data register with write enable and the
// bit recording whether the lane has been written in the current word.
module demux_lane #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mask_clr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  written
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out <= '0;
      written  <= 1'b0;
    end else begin
      if (en) data_out <= data_in;
      // A mask flush that coincides with a write leaves only this lane marked.
      if (mask_clr)  written <= en;
      else if (en)   written <= 1'b1;
    end
  end

endmodule

// File: rtl/demux_1_4_collector.sv
// Sequential 1:4 demux that gathers lane-serial writes into a word and
// flags completion (wordValid) and rewrites of already-filled lanes.
module demux_1_4_collector
  import demux_1_4_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter bit AUTO_CLEAR = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       inputData,
  input  logic [SEL_WIDTH-1:0]        selection,
  input  logic                        inputValid,
  input  logic                        clear,
  output logic [LANES*DATA_WIDTH-1:0] outputData,
  output logic [LANES-1:0]            writtenMask,
  output logic                        wordValid,
  output logic                        overwriteErr
);

  state_t           state, state_next;
  logic [LANES-1:0] sel_hot;
  logic [LANES-1:0] lane_en;
  logic             write;
  logic             restart;
  logic             mask_clr;
  logic             word_done;
  logic             overwrite;

  assign write    = inputValid & ~clear;
  assign sel_hot  = lane_onehot(selection);
  assign lane_en  = write ? sel_hot : '0;

  // With AUTO_CLEAR, a complete word is retired on the next edge, so any
  // write in that cycle starts a fresh word instead of overwriting.
  assign restart  = AUTO_CLEAR && (state == COMPLETE);
  assign mask_clr = clear | restart;

  assign word_done = (state == FILLING) & write & (&(writtenMask | sel_hot));
  assign overwrite = write & ~restart & (|(writtenMask & sel_hot));

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .en       (lane_en[k]),
      .mask_clr (mask_clr),
      .data_in  (inputData),
      .data_out (outputData[k*DATA_WIDTH +: DATA_WIDTH]),
      .written  (writtenMask[k])
    );
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (write) state_next = FILLING;
      FILLING:  if (word_done) state_next = COMPLETE;
      COMPLETE: if (AUTO_CLEAR) state_next = write ? FILLING : IDLE;
      default:  state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      wordValid    <= 1'b0;
      overwriteErr <= 1'b0;
    end else begin
      state        <= state_next;
      wordValid    <= word_done;
      overwriteErr <= overwrite;
    end
  end

endmodule

// File: tb/tb_demux_1_4_collector.sv
// Scoreboard bench for the lane collector: instance A (1-bit lanes, auto
// clear) and instance B (4-bit lanes, sticky mask) driven by directed vectors.
module tb_demux_1_4_collector;

  logic        clk = 1'b0;
  logic        rst_a, clr_a, vld_a, din_a;
  logic [1:0]  sel_a;
  logic [3:0]  out_a, mask_a;
  logic        wv_a, oe_a;
  logic        rst_b, clr_b, vld_b;
  logic [3:0]  din_b;
  logic [1:0]  sel_b;
  logic [15:0] out_b;
  logic [3:0]  mask_b;
  logic        wv_b, oe_b;

  always #5 clk = ~clk;

  demux_1_4_collector #(.DATA_WIDTH(1), .AUTO_CLEAR(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .inputData(din_a), .selection(sel_a),
    .inputValid(vld_a), .clear(clr_a), .outputData(out_a),
    .writtenMask(mask_a), .wordValid(wv_a), .overwriteErr(oe_a)
  );

  demux_1_4_collector #(.DATA_WIDTH(4), .AUTO_CLEAR(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .inputData(din_b), .selection(sel_b),
    .inputValid(vld_b), .clear(clr_b), .outputData(out_b),
    .writtenMask(mask_b), .wordValid(wv_b), .overwriteErr(oe_b)
  );

  typedef struct {
    bit          b;
    logic [15:0] data;
    logic [3:0]  mask;
    logic        wv;
    logic        oe;
    string       nm;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] mdata [2];
  logic [3:0]  mmask [2];

  // Monitor: one expected record per clock, compared on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [15:0] ad;
      logic [3:0]  am;
      logic        awv, aoe;
      e   = q.pop_front();
      ad  = e.b ? out_b  : {12'h000, out_a};
      am  = e.b ? mask_b : mask_a;
      awv = e.b ? wv_b   : wv_a;
      aoe = e.b ? oe_b   : oe_a;
      checks++;
      if (ad !== e.data || am !== e.mask || awv !== e.wv || aoe !== e.oe) begin
        failures++;
        $display("FAIL %s dut=%0d got data=%h mask=%b wv=%b oe=%b expected data=%h mask=%b wv=%b oe=%b",
                 e.nm, e.b, ad, am, awv, aoe, e.data, e.mask, e.wv, e.oe);
      end
    end
  end

  task automatic step(input bit b, input bit r, input bit c, input bit v,
                      input logic [1:0] s, input logic [3:0] d,
                      input logic [15:0] ed, input logic [3:0] em,
                      input logic ewv, input logic eoe, input string nm);
    exp_t e;
    @(negedge clk);
    rst_a = 1'b1; clr_a = 1'b0; vld_a = 1'b0; sel_a = 2'd0; din_a = 1'b0;
    rst_b = 1'b1; clr_b = 1'b0; vld_b = 1'b0; sel_b = 2'd0; din_b = 4'h0;
    if (b) begin
      rst_b = r; clr_b = c; vld_b = v; sel_b = s; din_b = d;
    end else begin
      rst_a = r; clr_a = c; vld_a = v; sel_a = s; din_a = d[0];
    end
    @(posedge clk);
    e.b = b; e.data = ed; e.mask = em; e.wv = ewv; e.oe = eoe; e.nm = nm;
    q.push_back(e);
  endtask

  // Random step: expected values come from a behavioural model of the word.
  task automatic rnd_step(input bit b);
    bit          r, c, v, ac, wv, oe;
    logic [1:0]  s;
    logic [3:0]  d, oh;
    logic [15:0] md;
    logic [3:0]  mm;
    int          w;
    w  = b ? 4 : 1;
    ac = !b;
    r  = ($urandom_range(0, 31) != 0);
    c  = ($urandom_range(0, 7) == 0);
    v  = ($urandom_range(0, 3) != 0);
    s  = 2'($urandom_range(0, 3));
    d  = 4'($urandom_range(0, 15)) & (b ? 4'hF : 4'h1);
    oh = 4'b0001 << s;
    md = mdata[b];
    mm = mmask[b];
    wv = 1'b0;
    oe = 1'b0;
    if (!r) begin
      md = '0;
      mm = '0;
    end else if (c) begin
      mm = '0;
    end else if (ac && mm == 4'hF) begin
      mm = v ? oh : 4'h0;
      if (v) for (int i = 0; i < w; i++) md[int'(s)*w + i] = d[i];
    end else if (v) begin
      oe = |(mm & oh);
      wv = (mm != 4'hF) && ((mm | oh) == 4'hF);
      mm = mm | oh;
      for (int i = 0; i < w; i++) md[int'(s)*w + i] = d[i];
    end
    mdata[b] = md;
    mmask[b] = mm;
    step(b, r, c, v, s, d, md, mm, wv, oe, b ? "rnd_b" : "rnd_a");
  endtask

  initial begin
    rst_a = 1'b0; clr_a = 1'b0; vld_a = 1'b0; sel_a = 2'd0; din_a = 1'b0;
    rst_b = 1'b0; clr_b = 1'b0; vld_b = 1'b0; sel_b = 2'd0; din_b = 4'h0;

    // Instance A: 1-bit lanes, AUTO_CLEAR=1
    step(0, 0, 0, 0, 0, 0, 16'h0, 4'h0, 0, 0, "a_reset0");
    step(0, 0, 0, 0, 0, 0, 16'h0, 4'h0, 0, 0, "a_reset1");
    step(0, 1, 0, 1, 0, 1, 16'h1, 4'h1, 0, 0, "a_fill_l0");
    step(0, 1, 0, 1, 1, 0, 16'h1, 4'h3, 0, 0, "a_fill_l1");
    step(0, 1, 0, 1, 2, 1, 16'h5, 4'h7, 0, 0, "a_fill_l2");
    step(0, 1, 0, 1, 3, 1, 16'hD, 4'hF, 1, 0, "a_fill_l3");
    step(0, 1, 0, 0, 0, 0, 16'hD, 4'h0, 0, 0, "a_autoclear");
    step(0, 1, 0, 1, 2, 1, 16'hD, 4'h4, 0, 0, "a_ooo_s2");
    step(0, 1, 0, 1, 2, 0, 16'h9, 4'h4, 0, 1, "a_overwrite");
    step(0, 1, 0, 1, 0, 1, 16'h9, 4'h5, 0, 0, "a_ooo_s0");
    step(0, 1, 0, 1, 3, 1, 16'h9, 4'hD, 0, 0, "a_ooo_s3");
    step(0, 1, 0, 1, 1, 1, 16'hB, 4'hF, 1, 0, "a_ooo_s1");
    step(0, 1, 0, 1, 1, 0, 16'h9, 4'h2, 0, 0, "a_b2b_word");
    step(0, 1, 0, 1, 0, 0, 16'h8, 4'h3, 0, 0, "a_pre_clear");
    step(0, 1, 1, 1, 2, 1, 16'h8, 4'h0, 0, 0, "a_clear_vs_write");
    step(0, 1, 0, 1, 0, 1, 16'h9, 4'h1, 0, 0, "a_w2_l0");
    step(0, 1, 0, 1, 1, 1, 16'hB, 4'h3, 0, 0, "a_w2_l1");
    step(0, 1, 0, 1, 2, 1, 16'hF, 4'h7, 0, 0, "a_w2_l2");
    step(0, 1, 0, 1, 3, 0, 16'h7, 4'hF, 1, 0, "a_w2_l3");
    step(0, 1, 1, 0, 0, 0, 16'h7, 4'h0, 0, 0, "a_clear_in_wv");
    step(0, 1, 0, 1, 0, 1, 16'h7, 4'h1, 0, 0, "a_w3_l0");
    step(0, 1, 0, 1, 1, 0, 16'h5, 4'h3, 0, 0, "a_w3_l1");
    step(0, 1, 0, 1, 2, 1, 16'h5, 4'h7, 0, 0, "a_w3_l2");
    step(0, 0, 0, 1, 3, 1, 16'h0, 4'h0, 0, 0, "a_midword_reset");
    step(0, 1, 0, 0, 0, 0, 16'h0, 4'h0, 0, 0, "a_after_reset");

    // Instance B: 4-bit lanes, AUTO_CLEAR=0
    step(1, 0, 0, 0, 0, 0, 16'h0000, 4'h0, 0, 0, "b_reset0");
    step(1, 0, 0, 0, 0, 0, 16'h0000, 4'h0, 0, 0, "b_reset1");
    step(1, 1, 0, 1, 0, 4'hA, 16'h000A, 4'h1, 0, 0, "b_fill_l0");
    step(1, 1, 0, 1, 1, 4'h5, 16'h005A, 4'h3, 0, 0, "b_fill_l1");
    step(1, 1, 0, 1, 2, 4'h3, 16'h035A, 4'h7, 0, 0, "b_fill_l2");
    step(1, 1, 0, 1, 3, 4'hC, 16'hC35A, 4'hF, 1, 0, "b_fill_l3");
    step(1, 1, 0, 0, 0, 0, 16'hC35A, 4'hF, 0, 0, "b_sticky_full");
    step(1, 1, 0, 1, 1, 4'hF, 16'hC3FA, 4'hF, 0, 1, "b_write_complete");
    step(1, 1, 0, 0, 0, 0, 16'hC3FA, 4'hF, 0, 0, "b_no_repulse");
    step(1, 1, 1, 0, 0, 0, 16'hC3FA, 4'h0, 0, 0, "b_clear");
    step(1, 1, 0, 1, 3, 4'h1, 16'h13FA, 4'h8, 0, 0, "b_new_word");

    // Randomised runs from a known reset state
    step(0, 0, 0, 0, 0, 0, 16'h0, 4'h0, 0, 0, "a_rnd_reset");
    mdata[0] = '0; mmask[0] = '0;
    for (int i = 0; i < 200; i++) rnd_step(1'b0);
    step(1, 0, 0, 0, 0, 0, 16'h0, 4'h0, 0, 0, "b_rnd_reset");
    mdata[1] = '0; mmask[1] = '0;
    for (int i = 0; i < 200; i++) rnd_step(1'b1);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
